cic_decimator: RTL and testbench

//  Multistage CIC decimator (N integrators, N combs, differential delay 1), power-of-two ratio.

---
 rtl/cic_decimator_if.sv | 23 ++
 rtl/cic_decimator.sv | 128 ++++++++++++
 tb/tb_cic_decimator.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cic_decimator_if.sv
// Sample stream bundle between the CIC decimator and its neighbours in the DFE chain.
// The master drives the input samples and ratio controls. The slave returns the decimated samples.
interface cic_decimator_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SEL_WIDTH  = 3
);
  logic                  valid_in;
  logic                  bypass;
  logic [SEL_WIDTH-1:0]  dec_log2;
  logic [DATA_WIDTH-1:0] filter_in;
  logic [DATA_WIDTH-1:0] filter_out;
  logic                  valid_out;

  modport master (
    output valid_in, bypass, dec_log2, filter_in,
    input  filter_out, valid_out
  );

  modport slave (
    input  valid_in, bypass, dec_log2, filter_in,
    output filter_out, valid_out
  );
endinterface

// File: rtl/cic_decimator.sv
// N-stage CIC decimator with a power-of-two ratio and a differential delay of 1.
// Gain is normalised by a rounding arithmetic shift, so the DC gain is exactly 1.
module cic_decimator #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DATA_FRAC  = 15,
  parameter int unsigned N_STAGE    = 5,
  parameter int unsigned LOG2_RMAX  = 4
) (
  input  logic           clk,
  input  logic           rst,
  cic_decimator_if.slave bus
);
  localparam int unsigned ACC_WIDTH = DATA_WIDTH + N_STAGE * LOG2_RMAX;
  localparam int unsigned SEL_WIDTH = $clog2(LOG2_RMAX + 1);
  localparam int unsigned SHIFT_W   = $clog2(N_STAGE * LOG2_RMAX + 1);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  if (DATA_FRAC >= DATA_WIDTH) begin : g_frac_check
    $error("DATA_FRAC must leave at least one integer bit");
  end

  logic [SEL_WIDTH-1:0]  dec_log2_q, dec_log2_d;
  logic [LOG2_RMAX-1:0]  cnt_q, cnt_d;
  acc_t                  integ_q [N_STAGE];
  acc_t                  integ_d [N_STAGE];
  acc_t                  dly_q   [N_STAGE];
  acc_t                  dly_d   [N_STAGE];
  logic [DATA_WIDTH-1:0] filter_out_q, filter_out_d;
  logic                  valid_out_q, valid_out_d;

  logic [SEL_WIDTH-1:0]  ratio_sel_c;
  logic [LOG2_RMAX-1:0]  cnt_last_c;
  logic [SHIFT_W-1:0]    shift_c;
  logic                  flush_c;
  logic                  strobe_c;
  acc_t                  integ_new_c [N_STAGE];
  acc_t                  comb_c      [N_STAGE+1];
  acc_t                  round_c;

  // Ratio decode: clamp out-of-range selections to the maximum ratio.
  always_comb begin
    ratio_sel_c = (dec_log2_q > SEL_WIDTH'(LOG2_RMAX)) ? SEL_WIDTH'(LOG2_RMAX) : dec_log2_q;
    cnt_last_c  = LOG2_RMAX'((32'd1 << ratio_sel_c) - 32'd1);
    shift_c     = SHIFT_W'(N_STAGE * ratio_sel_c);
    flush_c     = (bus.dec_log2 != dec_log2_q);
    strobe_c    = bus.valid_in & ~bus.bypass & ~flush_c & (cnt_q == cnt_last_c);
  end

  // Non-pipelined integrator cascade, comb cascade and rounding. All sums wrap modulo 2^ACC_WIDTH.
  always_comb begin
    integ_new_c[0] = integ_q[0] + ACC_WIDTH'($signed(bus.filter_in));
    for (int k = 1; k < N_STAGE; k++) begin
      integ_new_c[k] = integ_q[k] + integ_new_c[k-1];
    end
    comb_c[0] = integ_new_c[N_STAGE-1];
    for (int k = 0; k < N_STAGE; k++) begin
      comb_c[k+1] = comb_c[k] - dly_q[k];
    end
    round_c = comb_c[N_STAGE];
    if (shift_c != '0) begin
      round_c = comb_c[N_STAGE] + (acc_t'(1) << (shift_c - SHIFT_W'(1)));
    end
  end

  // Next state: bypass and ratio flush both return the filter to a clean zero state.
  always_comb begin
    dec_log2_d   = bus.dec_log2;
    cnt_d        = cnt_q;
    integ_d      = integ_q;
    dly_d        = dly_q;
    filter_out_d = filter_out_q;
    valid_out_d  = 1'b0;

    if (bus.bypass) begin
      cnt_d        = '0;
      for (int k = 0; k < N_STAGE; k++) begin
        integ_d[k] = '0;
        dly_d[k]   = '0;
      end
      filter_out_d = bus.filter_in;
      valid_out_d  = bus.valid_in;
    end else if (flush_c) begin
      cnt_d = '0;
      for (int k = 0; k < N_STAGE; k++) begin
        integ_d[k] = '0;
        dly_d[k]   = '0;
      end
    end else if (bus.valid_in) begin
      integ_d = integ_new_c;
      if (strobe_c) begin
        cnt_d        = '0;
        for (int k = 0; k < N_STAGE; k++) begin
          dly_d[k] = comb_c[k];
        end
        filter_out_d = DATA_WIDTH'(round_c >>> shift_c);
        valid_out_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + LOG2_RMAX'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_log2_q   <= '0;
      cnt_q        <= '0;
      filter_out_q <= '0;
      valid_out_q  <= 1'b0;
      for (int k = 0; k < N_STAGE; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
    end else begin
      dec_log2_q   <= dec_log2_d;
      cnt_q        <= cnt_d;
      filter_out_q <= filter_out_d;
      valid_out_q  <= valid_out_d;
      for (int k = 0; k < N_STAGE; k++) begin
        integ_q[k] <= integ_d[k];
        dly_q[k]   <= dly_d[k];
      end
    end
  end

  assign bus.filter_out = filter_out_q;
  assign bus.valid_out  = valid_out_q;
endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator. It covers reset, impulse, DC, wrap, ratio change, bypass and gapped streams.
// The gapped-stream expectations come from a direct FIR convolution with the CIC impulse response.
module tb_cic_decimator;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [15:0] outs[$];
  int          valids_seen;
  int          first_out_at;

  cic_decimator_if #(.DATA_WIDTH(16), .SEL_WIDTH(3)) bus ();

  cic_decimator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle just after a falling edge, then sample the registered outputs at the next falling edge.
  task automatic cycle(input logic v, input logic [15:0] x);
    bus.valid_in  = v;
    bus.filter_in = x;
    @(negedge clk);
    if (v) valids_seen++;
    if (bus.valid_out) begin
      outs.push_back(bus.filter_out);
      if (first_out_at < 0) first_out_at = valids_seen;
    end
  endtask

  task automatic clear_log();
    outs.delete();
    valids_seen  = 0;
    first_out_at = -1;
  endtask

  // A bypass cycle zeroes all filter state. The selected ratio is loaded meanwhile.
  task automatic clean(input logic [2:0] r);
    bus.bypass   = 1'b1;
    bus.dec_log2 = r;
    cycle(1'b0, 16'h0000);
    bus.bypass = 1'b0;
    cycle(1'b0, 16'h0000);
    cycle(1'b0, 16'h0000);
    clear_log();
  endtask

  function automatic logic [15:0] cic_model(input int lg, input int xs[$], input int n);
    longint h [80];
    longint g [80];
    longint acc;
    int     len;
    int     r;
    int     s;
    r = 1 << lg;
    len = 1;
    for (int i = 0; i < 80; i++) h[i] = 0;
    h[0] = 1;
    for (int st = 0; st < 5; st++) begin
      for (int i = 0; i < 80; i++) g[i] = 0;
      for (int i = 0; i < len + r - 1; i++)
        for (int j = 0; j < r; j++)
          if (i - j >= 0 && i - j < len) g[i] += h[i-j];
      len = len + r - 1;
      h = g;
    end
    acc = 0;
    for (int k = 0; k < len; k++)
      if (n - k >= 0 && n - k < xs.size()) acc += h[k] * longint'(xs[n-k]);
    s = 5 * lg;
    if (s > 0) acc += longint'(1) << (s - 1);
    return 16'(acc >>> s);
  endfunction

  task automatic test_reset();
    n_vec++;
    if (bus.filter_out !== 16'h0000) begin
      n_err++; $display("FAIL reset_filter_out got %h exp 0000", bus.filter_out);
    end
    n_vec++;
    if (bus.valid_out !== 1'b0) begin
      n_err++; $display("FAIL reset_valid_out got %b exp 0", bus.valid_out);
    end
    rst = 1'b0;
    cycle(1'b0, 16'h0000);
    cycle(1'b0, 16'h0000);
    clear_log();
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'h1000);
    n_vec++;
    if (bus.valid_out !== 1'b1 || bus.filter_out !== 16'h1000) begin
      n_err++; $display("FAIL pre_reset_out got v=%b %h exp v=1 1000", bus.valid_out, bus.filter_out);
    end
    // Reset lands between clock edges while a sample is being offered.
    bus.valid_in  = 1'b1;
    bus.filter_in = 16'h1000;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.filter_out !== 16'h0000 || bus.valid_out !== 1'b0) begin
      n_err++; $display("FAIL midstream_reset got v=%b %h exp v=0 0000", bus.valid_out, bus.filter_out);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.dec_log2 = 3'd2;
    cycle(1'b0, 16'h0000);
    cycle(1'b0, 16'h0000);
    clear_log();
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h1000);
    n_vec++;
    if (first_out_at !== 4) begin
      n_err++; $display("FAIL post_reset_first_strobe got %0d exp 4", first_out_at);
    end
    n_vec++;
    if (bus.filter_out !== 16'h00E0) begin
      n_err++; $display("FAIL post_reset_value got %h exp 00e0", bus.filter_out);
    end
  endtask

  task automatic test_impulse();
    logic [15:0] exp_v [4];
    logic [15:0] got;
    exp_v = '{16'd5, 16'd10, 16'd1, 16'd0};
    clean(3'd1);
    cycle(1'b1, 16'h0020);
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'h0000);
    n_vec++;
    if (outs.size() !== 4) begin
      n_err++; $display("FAIL impulse_count got %0d exp 4", outs.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < outs.size()) ? outs[i] : 16'hxxxx;
      n_vec++;
      if (got !== exp_v[i]) begin
        n_err++; $display("FAIL impulse[%0d] got %h exp %h", i, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_dc();
    logic [15:0] lv [3];
    logic [15:0] got;
    lv = '{16'h4000, 16'h7FFF, 16'h8000};
    for (int t = 0; t < 3; t++) begin
      clean(3'd2);
      for (int i = 0; i < 32; i++) cycle(1'b1, lv[t]);
      n_vec++;
      if (outs.size() !== 8) begin
        n_err++; $display("FAIL dc_count[%h] got %0d exp 8", lv[t], outs.size());
      end
      for (int i = 4; i < 8; i++) begin
        got = (i < outs.size()) ? outs[i] : 16'hxxxx;
        n_vec++;
        if (got !== lv[t]) begin
          n_err++; $display("FAIL dc[%h][%0d] got %h exp %h", lv[t], i, got, lv[t]);
        end
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 16'h1234);
      n_vec++;
      if (bus.valid_out !== 1'b0 || bus.filter_out !== lv[t]) begin
        n_err++; $display("FAIL dc_hold[%h] got v=%b %h exp v=0 %h", lv[t], bus.valid_out, bus.filter_out, lv[t]);
      end
    end
  endtask

  task automatic test_wrap();
    clean(3'd4);
    for (int i = 0; i < 10000; i++) cycle(1'b1, 16'h7FFF);
    n_vec++;
    if (outs.size() !== 625) begin
      n_err++; $display("FAIL wrap_count got %0d exp 625", outs.size());
    end
    for (int i = 5; i < outs.size(); i++) begin
      n_vec++;
      if (outs[i] !== 16'h7FFF) begin
        n_err++; $display("FAIL wrap[%0d] got %h exp 7fff", i, outs[i]);
      end
    end
  endtask

  task automatic test_ratio_change();
    logic [15:0] got;
    clean(3'd1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'h1000);
    // This sample would be a strobe at the old ratio. The flush must swallow it.
    bus.dec_log2 = 3'd3;
    cycle(1'b1, 16'h1000);
    n_vec++;
    if (outs.size() !== 3) begin
      n_err++; $display("FAIL flush_cycle_outputs got %0d exp 3", outs.size());
    end
    clear_log();
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'h1000);
    n_vec++;
    if (first_out_at !== 8) begin
      n_err++; $display("FAIL ratio_first_strobe got %0d exp 8", first_out_at);
    end
    n_vec++;
    if (outs.size() !== 1) begin
      n_err++; $display("FAIL ratio_count got %0d exp 1", outs.size());
    end
    got = (outs.size() > 0) ? outs[0] : 16'hxxxx;
    n_vec++;
    if (got !== 16'h0063) begin
      n_err++; $display("FAIL ratio_value got %h exp 0063", got);
    end
  endtask

  task automatic test_bypass();
    logic        vv [6];
    logic [15:0] xv [6];
    vv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    xv = '{16'h1234, 16'hBEEF, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF};
    bus.bypass = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.valid_in  = vv[i];
      bus.filter_in = xv[i];
      @(negedge clk);
      n_vec++;
      if (bus.filter_out !== xv[i]) begin
        n_err++; $display("FAIL bypass_data[%0d] got %h exp %h", i, bus.filter_out, xv[i]);
      end
      n_vec++;
      if (bus.valid_out !== vv[i]) begin
        n_err++; $display("FAIL bypass_valid[%0d] got %b exp %b", i, bus.valid_out, vv[i]);
      end
    end
  endtask

  // The ratio is left unchanged across the bypass exit, so only bypass can have cleared the state.
  task automatic test_gaps();
    int          xs[$];
    logic [15:0] x;
    logic [15:0] got;
    logic [15:0] exp_v;
    bus.bypass = 1'b0;
    clear_log();
    for (int i = 0; i < 64; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) cycle(1'b0, 16'($urandom));
      x = 16'($urandom);
      xs.push_back(int'($signed(x)));
      cycle(1'b1, x);
    end
    n_vec++;
    if (outs.size() !== 8) begin
      n_err++; $display("FAIL gaps_count got %0d exp 8", outs.size());
    end
    for (int m = 0; m < 8; m++) begin
      exp_v = cic_model(3, xs, 8 * m + 7);
      got   = (m < outs.size()) ? outs[m] : 16'hxxxx;
      n_vec++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL gaps[%0d] got %h exp %h", m, got, exp_v);
      end
    end
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.valid_in  = 1'b0;
    bus.bypass    = 1'b0;
    bus.dec_log2  = 3'd1;
    bus.filter_in = 16'h0000;
    clear_log();
    repeat (2) @(negedge clk);
    test_reset();
    test_impulse();
    test_dc();
    test_wrap();
    test_ratio_change();
    test_bypass();
    test_gaps();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
